// File: rtl/mlp_pkg.sv
// Shared types and fixed-point helpers for the time-multiplexed MLP.
package mlp_pkg;

  typedef enum logic [1:0] {IDLE, L1, L2, DONE} state_e;

  localparam int WIDE = 64;

  // Arithmetic shift then clamp to a dw-bit signed range; ovf flags a clamp.
  function automatic logic signed [WIDE-1:0] sat_shift(input logic signed [WIDE-1:0] x,
                                                       input int sh, input int dw,
                                                       output logic ovf);
    logic signed [WIDE-1:0] s, hi, lo;
    s   = x >>> sh;
    hi  = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo  = -(64'sd1 <<< (dw - 1));
    ovf = 1'b0;
    if (s > hi) begin
      ovf = 1'b1;
      s   = hi;
    end else if (s < lo) begin
      ovf = 1'b1;
      s   = lo;
    end
    return s;
  endfunction

  function automatic logic signed [WIDE-1:0] relu(input logic signed [WIDE-1:0] x);
    return x[WIDE-1] ? '0 : x;
  endfunction

endpackage

// File: rtl/mlp_mac.sv
// Shared signed multiply-accumulate with bias preload and saturating finalise.
module mlp_mac
  import mlp_pkg::*;
#(
  parameter int DW    = 8,
  parameter int AW    = 24,
  parameter int SHIFT = 4
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 load,
  input  logic signed [DW-1:0] bias,
  input  logic                 en,
  input  logic signed [DW-1:0] a,
  input  logic signed [DW-1:0] b,
  output logic signed [DW-1:0] res,
  output logic signed [DW-1:0] res_relu,
  output logic                 sat
);

  logic signed [AW-1:0]   acc, acc_next, bias_ext;
  logic signed [2*DW-1:0] prod;
  logic signed [WIDE-1:0] wide;

  // Results come from acc_next so the last product of a neuron is included.
  always_comb begin
    prod     = a * b;
    acc_next = acc + {{(AW-2*DW){prod[2*DW-1]}}, prod};
    bias_ext = {{(AW-DW){bias[DW-1]}}, bias} <<< SHIFT;
    wide     = {{(WIDE-AW){acc_next[AW-1]}}, acc_next};
    res      = DW'(sat_shift(wide, SHIFT, DW, sat));
    res_relu = DW'(relu(WIDE'(res)));
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      acc <= '0;
    end else if (load) begin
      acc <= bias_ext;
    end else if (en) begin
      acc <= acc_next;
    end
  end

endmodule

// File: rtl/mlp_seq.sv
// Sequential two-layer perceptron (ReLU hidden layer) around one shared MAC.
// Optional saturation flag output sat_o is enabled by defining MLP_SAT_FLAG_EN.
//
// state | meaning
// IDLE  | ready for an input vector
// L1    | one MAC per cycle over din x w1, writes hidden h[j]
// L2    | one MAC per cycle over h x w2, writes dout_o[k]
// DONE  | result valid, held until out_ready_i
module mlp_seq
  import mlp_pkg::*;
#(
  parameter int N_IN  = 6,
  parameter int N_HID = 16,
  parameter int N_OUT = 3,
  parameter int DW    = 8,
  parameter int AW    = 24,
  parameter int SHIFT = 4
) (
  input  logic                               clk_i,
  input  logic                               rstn_i,
  input  logic                               in_valid_i,
  output logic                               in_ready_o,
  input  logic [N_IN-1:0][DW-1:0]            din_i,
  input  logic [N_IN-1:0][N_HID-1:0][DW-1:0] w1_i,
  input  logic [N_HID-1:0][DW-1:0]           b1_i,
  input  logic [N_HID-1:0][N_OUT-1:0][DW-1:0] w2_i,
  input  logic [N_OUT-1:0][DW-1:0]           b2_i,
  output logic                               out_valid_o,
  input  logic                               out_ready_i,
  output logic [N_OUT-1:0][DW-1:0]           dout_o,
  output logic                               busy_o
`ifdef MLP_SAT_FLAG_EN
  , output logic                             sat_o
`endif
);

  localparam int NMAX = (N_IN > N_HID) ? ((N_IN > N_OUT) ? N_IN : N_OUT)
                                       : ((N_HID > N_OUT) ? N_HID : N_OUT);
  localparam int CW = $clog2(NMAX + 1);

  state_e                   state;
  logic [CW-1:0]            i, j, jn;
  logic [N_IN-1:0][DW-1:0]  din_r;
  logic [N_HID-1:0][DW-1:0] h;
  logic signed [DW-1:0]     a_sel, b_sel, bias_sel, res, res_relu;
  logic                     mac_sat, hs, in_layer, last_i, last_j, mac_load;

  assign hs       = in_valid_i & in_ready_o;
  assign in_layer = (state == L1) || (state == L2);
  assign last_i   = (state == L1) ? (i == CW'(N_IN - 1)) : (i == CW'(N_HID - 1));
  assign last_j   = (state == L1) ? (j == CW'(N_HID - 1)) : (j == CW'(N_OUT - 1));
  assign jn       = j + CW'(1);
  assign mac_load = hs | (in_layer & last_i);

  // Bias preload always targets the neuron evaluated next.
  always_comb begin
    a_sel    = '0;
    b_sel    = '0;
    bias_sel = '0;
    for (int n = 0; n < N_IN; n++) begin
      if (state == L1 && i == CW'(n)) begin
        a_sel = din_r[n];
        for (int m = 0; m < N_HID; m++) if (j == CW'(m)) b_sel = w1_i[n][m];
      end
    end
    for (int n = 0; n < N_HID; n++) begin
      if (state == L2 && i == CW'(n)) begin
        a_sel = h[n];
        for (int m = 0; m < N_OUT; m++) if (j == CW'(m)) b_sel = w2_i[n][m];
      end
    end
    if (state == IDLE) begin
      bias_sel = b1_i[0];
    end else if (state == L1) begin
      if (last_j) bias_sel = b2_i[0];
      else for (int m = 0; m < N_HID; m++) if (jn == CW'(m)) bias_sel = b1_i[m];
    end else begin
      for (int m = 0; m < N_OUT; m++) if (jn == CW'(m)) bias_sel = b2_i[m];
    end
  end

  mlp_mac #(.DW(DW), .AW(AW), .SHIFT(SHIFT)) u_mac (
    .clk_i    (clk_i),
    .rstn_i   (rstn_i),
    .load     (mac_load),
    .bias     (bias_sel),
    .en       (in_layer),
    .a        (a_sel),
    .b        (b_sel),
    .res      (res),
    .res_relu (res_relu),
    .sat      (mac_sat)
  );

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state       <= IDLE;
      i           <= '0;
      j           <= '0;
      din_r       <= '0;
      h           <= '0;
      dout_o      <= '0;
      in_ready_o  <= 1'b1;
      out_valid_o <= 1'b0;
      busy_o      <= 1'b0;
`ifdef MLP_SAT_FLAG_EN
      sat_o       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (hs) begin
          din_r      <= din_i;
          i          <= '0;
          j          <= '0;
          in_ready_o <= 1'b0;
          busy_o     <= 1'b1;
`ifdef MLP_SAT_FLAG_EN
          sat_o      <= 1'b0;
`endif
          state      <= L1;
        end
        L1: if (last_i) begin
          for (int m = 0; m < N_HID; m++) if (j == CW'(m)) h[m] <= res_relu;
`ifdef MLP_SAT_FLAG_EN
          sat_o <= sat_o | mac_sat;
`endif
          i <= '0;
          if (last_j) begin
            j     <= '0;
            state <= L2;
          end else begin
            j <= jn;
          end
        end else begin
          i <= i + CW'(1);
        end
        L2: if (last_i) begin
          for (int m = 0; m < N_OUT; m++) if (j == CW'(m)) dout_o[m] <= res;
`ifdef MLP_SAT_FLAG_EN
          sat_o <= sat_o | mac_sat;
`endif
          i <= '0;
          if (last_j) begin
            j           <= '0;
            out_valid_o <= 1'b1;
            state       <= DONE;
          end else begin
            j <= jn;
          end
        end else begin
          i <= i + CW'(1);
        end
        DONE: if (out_ready_i) begin
          out_valid_o <= 1'b0;
          in_ready_o  <= 1'b1;
          busy_o      <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mlp_seq.sv
// Scoreboard bench for mlp_seq: SHIFT=0 and SHIFT=4 instances share one stimulus stream.
module tb_mlp_seq;

  localparam int N_IN  = 6;
  localparam int N_HID = 16;
  localparam int N_OUT = 3;
  localparam int DW    = 8;
  localparam int LAT   = N_IN * N_HID + N_HID * N_OUT;
  localparam int HI    = (1 << (DW - 1)) - 1;
  localparam int LO    = -(1 << (DW - 1));

  typedef struct packed {
    logic                     sat;
    logic [N_OUT-1:0][DW-1:0] y;
  } exp_t;

  logic clk = 1'b0;
  logic rstn = 1'b1;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [N_IN-1:0][DW-1:0]             din = '0;
  logic [N_IN-1:0][N_HID-1:0][DW-1:0]  w1 = '0;
  logic [N_HID-1:0][DW-1:0]            b1 = '0;
  logic [N_HID-1:0][N_OUT-1:0][DW-1:0] w2 = '0;
  logic [N_OUT-1:0][DW-1:0]            b2 = '0;
  logic in_ready0, out_valid0, busy0, in_ready4, out_valid4, busy4;
  logic [N_OUT-1:0][DW-1:0] dout0, dout4;
`ifdef MLP_SAT_FLAG_EN
  logic sat0, sat4;
`endif

  int din_v[N_IN];
  int w1_v[N_IN][N_HID];
  int b1_v[N_HID];
  int w2_v[N_HID][N_OUT];
  int b2_v[N_OUT];

  exp_t q0[$];
  exp_t q4[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   neg_cnt = 0;
  int   hs_n = 0;
  logic prev0 = 1'b0;
  logic prev4 = 1'b0;

  always #5 clk = ~clk;

  mlp_seq #(.N_IN(N_IN), .N_HID(N_HID), .N_OUT(N_OUT), .DW(DW), .AW(24), .SHIFT(0)) u0 (
    .clk_i(clk), .rstn_i(rstn), .in_valid_i(in_valid), .in_ready_o(in_ready0),
    .din_i(din), .w1_i(w1), .b1_i(b1), .w2_i(w2), .b2_i(b2),
    .out_valid_o(out_valid0), .out_ready_i(out_ready), .dout_o(dout0), .busy_o(busy0)
`ifdef MLP_SAT_FLAG_EN
    , .sat_o(sat0)
`endif
  );

  mlp_seq #(.N_IN(N_IN), .N_HID(N_HID), .N_OUT(N_OUT), .DW(DW), .AW(24), .SHIFT(4)) u4 (
    .clk_i(clk), .rstn_i(rstn), .in_valid_i(in_valid), .in_ready_o(in_ready4),
    .din_i(din), .w1_i(w1), .b1_i(b1), .w2_i(w2), .b2_i(b2),
    .out_valid_o(out_valid4), .out_ready_i(out_ready), .dout_o(dout4), .busy_o(busy4)
`ifdef MLP_SAT_FLAG_EN
    , .sat_o(sat4)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int clamp(input int x, inout logic s);
    if (x > HI) begin s = 1'b1; return HI; end
    if (x < LO) begin s = 1'b1; return LO; end
    return x;
  endfunction

  // Reference: plain integer dense layers with scaled biases.
  function automatic exp_t model(input int sh);
    exp_t e;
    int   h[N_HID];
    int   acc, v;
    logic s;
    s = 1'b0;
    e = '0;
    for (int jj = 0; jj < N_HID; jj++) begin
      acc = b1_v[jj] * (1 << sh);
      for (int ii = 0; ii < N_IN; ii++) acc += din_v[ii] * w1_v[ii][jj];
      v = clamp(acc >>> sh, s);
      h[jj] = (v < 0) ? 0 : v;
    end
    for (int kk = 0; kk < N_OUT; kk++) begin
      acc = b2_v[kk] * (1 << sh);
      for (int ii = 0; ii < N_HID; ii++) acc += h[ii] * w2_v[ii][kk];
      v = clamp(acc >>> sh, s);
      e.y[kk] = DW'(v);
    end
    e.sat = s;
    return e;
  endfunction

  task automatic apply();
    for (int n = 0; n < N_IN; n++) din[n] = DW'(din_v[n]);
    for (int n = 0; n < N_IN; n++) for (int m = 0; m < N_HID; m++) w1[n][m] = DW'(w1_v[n][m]);
    for (int m = 0; m < N_HID; m++) b1[m] = DW'(b1_v[m]);
    for (int n = 0; n < N_HID; n++) for (int m = 0; m < N_OUT; m++) w2[n][m] = DW'(w2_v[n][m]);
    for (int m = 0; m < N_OUT; m++) b2[m] = DW'(b2_v[m]);
  endtask

  task automatic set_all(input int dv, input int w1c, input int b1c, input int w2c, input int b2c);
    for (int n = 0; n < N_IN; n++) din_v[n] = dv;
    for (int n = 0; n < N_IN; n++) for (int m = 0; m < N_HID; m++) w1_v[n][m] = w1c;
    for (int m = 0; m < N_HID; m++) b1_v[m] = b1c;
    for (int n = 0; n < N_HID; n++) for (int m = 0; m < N_OUT; m++) w2_v[n][m] = w2c;
    for (int m = 0; m < N_OUT; m++) b2_v[m] = b2c;
  endtask

  function automatic int rnd(input int span);
    return int'($urandom_range(2 * span - 1)) - span;
  endfunction

  task automatic set_rand(input int ws);
    for (int n = 0; n < N_IN; n++) din_v[n] = rnd(128);
    for (int n = 0; n < N_IN; n++) for (int m = 0; m < N_HID; m++) w1_v[n][m] = rnd(ws);
    for (int m = 0; m < N_HID; m++) b1_v[m] = rnd(128);
    for (int n = 0; n < N_HID; n++) for (int m = 0; m < N_OUT; m++) w2_v[n][m] = rnd(ws);
    for (int m = 0; m < N_OUT; m++) b2_v[m] = rnd(128);
  endtask

  task automatic send(input bit rdy_early);
    int t = 0;
    apply();
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready0 && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (t >= 400) chk("hs_timeout", 64'(t), 64'(0));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (rdy_early) out_ready = 1'b1;
  endtask

  task automatic wait_done();
    int t = 0;
    while (!out_valid0 && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (t >= 400) chk("done_timeout", 64'(t), 64'(0));
  endtask

  task automatic finish_out(input int hold, input bit pulse);
    for (int c = 0; c < hold; c++) begin
      @(posedge clk);
      #1;
      if (pulse && c == 3) begin
        for (int n = 0; n < N_IN; n++) din_v[n] = rnd(128);
        apply();
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      chk("hold_ctl", {in_ready0, busy0, out_valid0}, 3'b011);
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("release_ctl", {in_ready0, busy0, out_valid0}, 3'b100);
  endtask

  task automatic early_release();
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("early_release_ctl", {in_ready0, busy0, out_valid0}, 3'b100);
  endtask

  always @(negedge clk) begin
    exp_t e;
    neg_cnt++;
    if (!rstn) begin
      prev0 = 1'b0;
      prev4 = 1'b0;
    end else begin
      if (in_valid && in_ready0) begin
        q0.push_back(model(0));
        q4.push_back(model(4));
        hs_n = neg_cnt;
      end
      if (out_valid0 && !prev0) chk("latency0", 64'(neg_cnt - hs_n), 64'(LAT + 1));
      if (out_valid4 && !prev4) chk("latency4", 64'(neg_cnt - hs_n), 64'(LAT + 1));
      if (out_valid0) begin
        if (q0.size() == 0) chk("q0_empty", 64'(0), 64'(1));
        else begin
          e = q0[0];
          chk("dout_s0", 64'(dout0), 64'(e.y));
`ifdef MLP_SAT_FLAG_EN
          chk("sat_s0", 64'(sat0), 64'(e.sat));
`endif
          if (out_ready) void'(q0.pop_front());
        end
      end
      if (out_valid4) begin
        if (q4.size() == 0) chk("q4_empty", 64'(0), 64'(1));
        else begin
          e = q4[0];
          chk("dout_s4", 64'(dout4), 64'(e.y));
`ifdef MLP_SAT_FLAG_EN
          chk("sat_s4", 64'(sat4), 64'(e.sat));
`endif
          if (out_ready) void'(q4.pop_front());
        end
      end
      prev0 = out_valid0;
      prev4 = out_valid4;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    set_all(0, 0, 0, 0, 0);
    apply();
    #1 rstn = 1'b0;
    #1;
    chk("reset_u0", {in_ready0, out_valid0, busy0, dout0}, {3'b100, 24'h0});
    chk("reset_u4", {in_ready4, out_valid4, busy4, dout4}, {3'b100, 24'h0});
    repeat (3) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // zero weights, only output biases survive
    set_rand(128);
    for (int n = 0; n < N_IN; n++) for (int m = 0; m < N_HID; m++) w1_v[n][m] = 0;
    for (int m = 0; m < N_HID; m++) b1_v[m] = 0;
    for (int n = 0; n < N_HID; n++) for (int m = 0; m < N_OUT; m++) w2_v[n][m] = 0;
    for (int m = 0; m < N_OUT; m++) b2_v[m] = m + 1;
    send(0); wait_done(); finish_out(0, 0);

    // positive overflow clamps to +127
    set_all(0, 1, 0, 1, 0);
    for (int n = 0; n < N_IN; n++) din_v[n] = n + 1;
    send(0); wait_done(); finish_out(0, 0);

    // negative hidden values removed by ReLU
    set_all(1, -1, 0, 3, -5);
    send(0); wait_done(); finish_out(0, 0);

    // fixed-point scaling
    set_all(16, 16, 0, 0, 2);
    send(0); wait_done(); finish_out(0, 0);

    // backpressure with an ignored input pulse
    set_rand(16);
    send(0); wait_done(); finish_out(10, 1);

    // reset in the middle of layer 1
    set_rand(16);
    send(0);
    repeat (50) @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("midreset_u0", {in_ready0, out_valid0, busy0, dout0}, {3'b100, 24'h0});
    chk("midreset_u4", {in_ready4, out_valid4, busy4, dout4}, {3'b100, 24'h0});
    q0.delete();
    q4.delete();
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    set_rand(16);
    send(0); wait_done(); finish_out(0, 0);

    // random traffic, out_ready high from the handshake onward
    for (int r = 0; r < 6; r++) begin
      set_rand((r % 2 == 0) ? 8 : 128);
      send(1); wait_done(); early_release();
    end

    repeat (3) @(posedge clk);
    chk("q0_drained", 64'(q0.size()), 64'(0));
    chk("q4_drained", 64'(q4.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
